argon_fetch_unit: RTL and testbench

- Parametrised instruction fetch front end for the Argon core. Replaces the fixed two-beat, 16-bit fetch sequence inside the control unit.
- Assembles INSTR_WIDTH-bit instructions from MEM_WIDTH-bit memory beats, with a ready handshake that supports wait states.
- Buffers completed instructions with their PCs in a FIFO_DEPTH-entry prefetch queue feeding decode.
- Supports halt and PC redirect (branch/jump) with queue flush.

---
 rtl/argon_fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_argon_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/argon_fetch_unit.sv
// Argon instruction fetch front end: assembles instructions from memory beats
// and buffers them with their PCs in a small prefetch queue for decode.
module argon_fetch_unit #(
    parameter int                    MEM_WIDTH   = 16,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    FIFO_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_halt,
    input  logic                         i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        i_redirect_pc,
    output logic [ADDR_WIDTH-1:0]        o_mem_address,
    output logic                         o_mem_re,
    input  logic                         i_mem_ready,
    input  logic [MEM_WIDTH-1:0]         i_mem_data,
    output logic                         o_instr_valid,
    output logic [INSTR_WIDTH-1:0]       o_instr,
    output logic [ADDR_WIDTH-1:0]        o_instr_pc,
    input  logic                         i_instr_ready,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);

    localparam int BEATS  = INSTR_WIDTH / MEM_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP  = ADDR_WIDTH'(MEM_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] INSTR_STEP = ADDR_WIDTH'(INSTR_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_WIDTH / 8 - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0]      LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL       = CNT_W'(FIFO_DEPTH);

    if ((MEM_WIDTH % 8 != 0) || (INSTR_WIDTH < MEM_WIDTH) ||
        (INSTR_WIDTH % MEM_WIDTH != 0) || (FIFO_DEPTH < 1)) begin : g_bad_params
        $error("argon_fetch_unit: illegal parameter combination");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    re_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [INSTR_WIDTH-1:0]  asm_q;
    logic [INSTR_WIDTH-1:0]  asm_d;

    logic [INSTR_WIDTH-1:0]  fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;

    logic                    last_beat;
    logic                    push;
    logic                    pop;
    logic                    room_next;
    logic [ADDR_WIDTH-1:0]   redirect_pc_aligned;
    logic [ADDR_WIDTH-1:0]   pc_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        asm_d = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                asm_d[b*MEM_WIDTH +: MEM_WIDTH] = i_mem_data;
            end
        end

        last_beat = (state_q == FETCH) && i_mem_ready && (beat_q == LAST_BEAT);
        // A redirect drops any same-cycle push or pop.
        push = last_beat && !i_redirect_valid;
        pop  = (count_q != '0) && i_instr_ready && !i_redirect_valid;

        count_d = count_q;
        if (i_redirect_valid) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        room_next           = (count_d < FULL);
        redirect_pc_aligned = i_redirect_pc & ~ALIGN_MASK;
        pc_next             = pc_q + INSTR_STEP;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            re_q    <= 1'b0;
            beat_q  <= '0;
            asm_q   <= '0;
        end else if (i_redirect_valid) begin
            state_q <= IDLE;
            pc_q    <= redirect_pc_aligned;
            addr_q  <= redirect_pc_aligned;
            re_q    <= 1'b0;
            beat_q  <= '0;
            asm_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!i_halt && (count_q < FULL)) begin
                        state_q <= FETCH;
                        re_q    <= 1'b1;
                        addr_q  <= pc_q;
                        beat_q  <= '0;
                    end
                end
                FETCH: begin
                    if (i_mem_ready) begin
                        if (beat_q != LAST_BEAT) begin
                            beat_q <= beat_q + BEAT_W'(1);
                            addr_q <= addr_q + BEAT_STEP;
                            asm_q  <= asm_d;
                        end else begin
                            // Halt is only honoured here, at an instruction boundary.
                            pc_q   <= pc_next;
                            beat_q <= '0;
                            asm_q  <= '0;
                            if (room_next && !i_halt) begin
                                addr_q <= pc_next;
                            end else begin
                                state_q <= IDLE;
                                re_q    <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    re_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            count_q <= count_d;
            if (i_redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_instr_q[wr_ptr_q] <= asm_d;
                    fifo_pc_q[wr_ptr_q]    <= pc_q;
                    wr_ptr_q               <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
            end
        end
    end

    assign o_mem_address = addr_q;
    assign o_mem_re      = re_q;
    assign o_instr_valid = (count_q != '0);
    assign o_instr       = fifo_instr_q[rd_ptr_q];
    assign o_instr_pc    = fifo_pc_q[rd_ptr_q];
    assign o_fifo_count  = count_q;

endmodule

// File: tb/tb_argon_fetch_unit.sv
// Bench for argon_fetch_unit: directed scenarios on a default and an 8-bit-bus
// instance, then randomized traffic checked against an in-order PC/byte model.
module tb_argon_fetch_unit;

    logic        clk;
    logic        rst_a, rst_b;
    logic        halt, redir;
    logic [15:0] redir_pc;

    logic [15:0] addr_a, addr_a1, pc_a, mem_data_a;
    logic        re_a, ready_a, valid_a, iready_a;
    logic [31:0] instr_a;
    logic [1:0]  count_a;

    logic [15:0] addr_b, pc_b;
    logic        re_b, ready_b, valid_b, iready_b;
    logic [7:0]  mem_data_b;
    logic [31:0] instr_b;
    logic [2:0]  count_b;

    logic [7:0]  mem_b [0:65535];

    int checks = 0;
    int errors = 0;

    assign addr_a1    = addr_a + 16'd1;
    assign mem_data_a = {mem_b[addr_a1], mem_b[addr_a]};
    assign mem_data_b = mem_b[addr_b];

    argon_fetch_unit dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_halt(halt),
        .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
        .o_mem_address(addr_a), .o_mem_re(re_a), .i_mem_ready(ready_a),
        .i_mem_data(mem_data_a), .o_instr_valid(valid_a), .o_instr(instr_a),
        .o_instr_pc(pc_a), .i_instr_ready(iready_a), .o_fifo_count(count_a)
    );

    argon_fetch_unit #(
        .MEM_WIDTH(8), .INSTR_WIDTH(32), .ADDR_WIDTH(16),
        .FIFO_DEPTH(4), .RESET_PC(16'hFFF8)
    ) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_halt(1'b0),
        .i_redirect_valid(1'b0), .i_redirect_pc(16'h0000),
        .o_mem_address(addr_b), .o_mem_re(re_b), .i_mem_ready(ready_b),
        .i_mem_data(mem_data_b), .o_instr_valid(valid_b), .o_instr(instr_b),
        .o_instr_pc(pc_b), .i_instr_ready(iready_b), .o_fifo_count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Little-endian instruction made of the four bytes at pc..pc+3 (wrapping).
    function automatic logic [31:0] instr32(input logic [15:0] pc);
        logic [15:0] p1, p2, p3;
        p1 = pc + 16'd1;
        p2 = pc + 16'd2;
        p3 = pc + 16'd3;
        return {mem_b[p3], mem_b[p2], mem_b[p1], mem_b[pc]};
    endfunction

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] exp_addr;
        int consumed;

        rst_a = 1'b1; rst_b = 1'b1;
        halt = 1'b0; redir = 1'b0; redir_pc = 16'h0;
        ready_a = 1'b1; iready_a = 1'b0;
        ready_b = 1'b1; iready_b = 1'b1;
        for (int i = 0; i < 65536; i++) mem_b[i] = 8'($urandom);
        mem_b[0] = 8'h34; mem_b[1] = 8'h12; mem_b[2] = 8'hCD; mem_b[3] = 8'hAB;

        // Reset state
        #1;
        chk("rst_re", re_a, 0);
        chk("rst_addr", addr_a, 16'h0000);
        chk("rst_valid", valid_a, 0);
        chk("rst_instr", instr_a, 0);
        chk("rst_pc", pc_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_b_addr", addr_b, 16'hFFF8);

        // Basic fetch, consumer stalled: fills queue then stops
        @(negedge clk); rst_a = 1'b0;
        @(negedge clk);
        chk("t1_re_e1", re_a, 1);
        chk("t1_addr_e1", addr_a, 16'h0000);
        chk("t1_valid_e1", valid_a, 0);
        @(negedge clk);
        chk("t1_addr_e2", addr_a, 16'h0002);
        chk("t1_valid_e2", valid_a, 0);
        @(negedge clk);
        chk("t1_valid_e3", valid_a, 1);
        chk("t1_instr", instr_a, 32'hABCD1234);
        chk("t1_pc", pc_a, 16'h0000);
        chk("t1_count_e3", count_a, 1);
        chk("t1_addr_e3", addr_a, 16'h0004);
        @(negedge clk);
        chk("t1_addr_e4", addr_a, 16'h0006);
        @(negedge clk);
        chk("t1_count_full", count_a, 2);
        chk("t1_re_stop", re_a, 0);
        chk("t1_head_pc", pc_a, 16'h0000);
        @(negedge clk);
        chk("t1_re_still0", re_a, 0);
        chk("t1_count_still2", count_a, 2);

        // Wait states: three not-ready cycles on each beat
        rst_a = 1'b1; ready_a = 1'b0;
        @(negedge clk); rst_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_addr_hold0", addr_a, 16'h0000);
            chk("t2_re_hold", re_a, 1);
        end
        ready_a = 1'b1;
        @(negedge clk);
        chk("t2_addr_beat1", addr_a, 16'h0002);
        ready_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_addr_hold2", addr_a, 16'h0002);
            chk("t2_valid_wait", valid_a, 0);
        end
        ready_a = 1'b1;
        @(negedge clk);
        chk("t2_valid", valid_a, 1);
        chk("t2_instr", instr_a, 32'hABCD1234);
        chk("t2_pc", pc_a, 16'h0000);
        chk("t2_addr_next", addr_a, 16'h0004);

        // Redirect during beat 1 with one queued entry; same-cycle pop dropped
        @(negedge clk);
        chk("t3_addr_beat1", addr_a, 16'h0006);
        chk("t3_count_pre", count_a, 1);
        redir = 1'b1; redir_pc = 16'h0103; iready_a = 1'b1;
        @(negedge clk);
        chk("t3_count_flush", count_a, 0);
        chk("t3_valid_flush", valid_a, 0);
        chk("t3_re_flush", re_a, 0);
        redir = 1'b0; iready_a = 1'b0;
        @(negedge clk);
        chk("t3_re_resume", re_a, 1);
        chk("t3_addr_resume", addr_a, 16'h0100);
        @(negedge clk);
        chk("t3_addr_b1", addr_a, 16'h0102);
        @(negedge clk);
        chk("t3_valid", valid_a, 1);
        chk("t3_pc", pc_a, 16'h0100);
        chk("t3_instr", instr_a, instr32(16'h0100));
        chk("t3_count", count_a, 1);

        // Halt raised mid-instruction: instruction completes, then fetch stops
        halt = 1'b1; iready_a = 1'b1;
        @(negedge clk);
        chk("t4_addr_mid", addr_a, 16'h0106);
        chk("t4_re_mid", re_a, 1);
        chk("t4_count_pop", count_a, 0);
        iready_a = 1'b0;
        @(negedge clk);
        chk("t4_re_drop", re_a, 0);
        chk("t4_count", count_a, 1);
        chk("t4_pc", pc_a, 16'h0104);
        chk("t4_instr", instr_a, instr32(16'h0104));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_re_halted", re_a, 0);
        end
        halt = 1'b0;
        @(negedge clk);
        chk("t4_re_resume", re_a, 1);
        chk("t4_addr_resume", addr_a, 16'h0108);

        // Reset asserted mid-beat with one queued entry
        @(negedge clk);
        chk("t6_addr_mid", addr_a, 16'h010A);
        chk("t6_count_pre", count_a, 1);
        #2 rst_a = 1'b1;
        #1;
        chk("t6_re", re_a, 0);
        chk("t6_valid", valid_a, 0);
        chk("t6_count", count_a, 0);
        chk("t6_addr", addr_a, 16'h0000);
        @(negedge clk); rst_a = 1'b0;
        @(negedge clk);
        chk("t6_re_restart", re_a, 1);
        chk("t6_addr_restart", addr_a, 16'h0000);
        @(negedge clk);
        chk("t6_addr_b1", addr_a, 16'h0002);
        @(negedge clk);
        chk("t6_valid_after", valid_a, 1);
        chk("t6_pc_after", pc_a, 16'h0000);
        chk("t6_instr_after", instr_a, 32'hABCD1234);

        // Byte-wide bus, 4-deep queue, reset PC near the top of memory
        @(negedge clk); rst_b = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_addr = 16'hFFF8 + 16'(k - 1);
            chk("t5_addr", addr_b, exp_addr);
            chk("t5_re", re_b, 1);
            if (k == 5 || k == 9 || k == 13) begin
                exp_pc = 16'hFFF8 + 16'(k - 5);
                chk("t5_valid", valid_b, 1);
                chk("t5_pc", pc_b, exp_pc);
                chk("t5_instr", instr_b, instr32(exp_pc));
                chk("t5_count", count_b, 1);
            end
        end

        // Randomized traffic against an in-order fetch-stream model
        rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        exp_pc = 16'h0000;
        consumed = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("rnd_valid_vs_count", valid_a, (count_a != 2'd0));
            chk("rnd_count_bound", (count_a <= 2'd2), 1);
            ready_a  = ($urandom_range(0, 9) < 7);
            iready_a = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            redir    = ($urandom_range(0, 49) == 0);
            redir_pc = 16'($urandom);
            if (redir) begin
                exp_pc = redir_pc & 16'hFFFC;
            end else if (valid_a && iready_a) begin
                chk("rnd_pc", pc_a, exp_pc);
                chk("rnd_instr", instr_a, instr32(exp_pc));
                exp_pc = exp_pc + 16'd4;
                consumed++;
            end
        end
        redir = 1'b0; halt = 1'b0; iready_a = 1'b0;
        chk("rnd_progress", (consumed > 100), 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
